// File: rtl/cs.sv
// -----------------------------------------------------------------------------
// cs : sliding-window comparator/selector filter
//
// Keeps the last nine 8-bit samples, forms their sum S and integer average
// Xavg = floor(S/9), picks Xappr = the largest window sample not exceeding
// Xavg, and outputs Y = floor((S + 9*Xappr) / 8).
//
// Ports
//   clk   : input  1  rising-edge clock
//   reset : input  1  synchronous active-high; clears the window (X not taken)
//   X     : input  8  unsigned sample, captured every non-reset rising edge
//   Y     : output 10 unsigned filter result for the current window
//
// Configuration macro
//   CS_OUTREG_EN : when defined, Y comes from a 10-bit register loaded each
//                  edge with the combinational result (one extra cycle of
//                  latency, cleared by reset). Undefined: Y is combinational
//                  from the window registers.
// -----------------------------------------------------------------------------
module cs (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] X,
  output logic [9:0] Y
);

  localparam int unsigned WIN_LEN = 9;

  logic [7:0]  window_q [WIN_LEN];
  logic [7:0]  window_d [WIN_LEN];

  logic [11:0] sum_s;
  logic [7:0]  xavg_s;
  logic [7:0]  xappr_s;
  logic [11:0] xappr_x9_s;
  logic [12:0] total_s;
  logic [9:0]  y_s;

  // Next window: clear on reset, otherwise shift X into W0 and drop W8.
  always_comb begin
    for (int i = 0; i < WIN_LEN; i++) begin
      window_d[i] = window_q[i];
    end
    if (reset) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        window_d[i] = 8'd0;
      end
    end else begin
      window_d[0] = X;
      for (int i = 1; i < WIN_LEN; i++) begin
        window_d[i] = window_q[i-1];
      end
    end
  end

  // Window register bank.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIN_LEN; i++) begin
      window_q[i] <= window_d[i];
    end
  end

  // Window sum; 9 * 255 = 2295 fits 12 bits.
  always_comb begin
    sum_s = 12'd0;
    for (int i = 0; i < WIN_LEN; i++) begin
      sum_s = sum_s + {4'd0, window_q[i]};
    end
  end

  // floor(S/9) never exceeds 255, so the 8-bit narrowing is lossless.
  assign xavg_s = 8'(sum_s / 12'd9);

  // Largest sample not above the average. Starting from 0 is safe: the
  // minimum sample is always <= the average, so a real candidate exists.
  always_comb begin
    xappr_s = 8'd0;
    for (int i = 0; i < WIN_LEN; i++) begin
      if ((window_q[i] <= xavg_s) && (window_q[i] > xappr_s)) begin
        xappr_s = window_q[i];
      end else begin
        xappr_s = xappr_s;
      end
    end
  end

  // 9*Xappr as (Xappr << 3) + Xappr keeps the multiply out of the critical path.
  assign xappr_x9_s = {1'b0, xappr_s, 3'b000} + {4'd0, xappr_s};
  assign total_s    = {1'b0, sum_s} + {1'b0, xappr_x9_s};
  // Max total is 4590, so total/8 <= 573 fits 10 bits exactly.
  assign y_s        = 10'(total_s >> 3);

`ifdef CS_OUTREG_EN
  logic [9:0] y_q;
  logic [9:0] y_d;

  // Output register load value: cleared with the window on reset.
  always_comb begin
    y_d = y_q;
    if (reset) begin
      y_d = 10'd0;
    end else begin
      y_d = y_s;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    y_q <= y_d;
  end

  assign Y = y_q;
`else
  assign Y = y_s;
`endif

endmodule

// File: tb/tb_cs.sv
// -----------------------------------------------------------------------------
// tb_cs : directed self-checking bench for cs.
// Each step drives reset/X at the falling edge and samples Y 1 ns after the
// following rising edge. With CS_OUTREG_EN the expectation of a step is
// compared one step later, matching the extra output register stage.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cs;

  logic       clk;
  logic       reset;
  logic [7:0] X;
  logic [9:0] Y;

  int checks;
  int failures;

  logic [9:0] pend_exp;
  bit         pend_chk;
  string      pend_tag;

  cs dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_check(input logic [9:0] exp, input string tag);
    checks++;
    assert (Y === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, Y, exp);
    end
  endtask

  // One clock step. exp is the Y value belonging to the window after this edge.
  task automatic step(input logic rst, input logic [7:0] x,
                      input logic [9:0] exp, input bit chk, input string tag);
    @(negedge clk);
    reset = rst;
    X     = x;
    @(posedge clk);
    #1;
`ifdef CS_OUTREG_EN
    if (rst) begin
      do_check(10'd0, {tag, "_regclr"});
    end else if (pend_chk) begin
      do_check(pend_exp, pend_tag);
    end
    pend_exp = exp;
    pend_chk = chk;
    pend_tag = tag;
`else
    if (chk) do_check(exp, tag);
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pend_exp = 10'd0;
    pend_chk = 1'b0;
    pend_tag = "none";
    reset    = 1'b1;
    X        = 8'd0;

    // Reset state
    step(1'b1, 8'd0, 10'd0, 1'b1, "reset_init");

    // Constant 10: first sample alone gives S=10, Xappr=0, Y=1; full window Y=22
    step(1'b0, 8'd10, 10'd1, 1'b1, "const10_first");
    for (int i = 1; i < 8; i++) step(1'b0, 8'd10, 10'd0, 1'b0, "fill");
    step(1'b0, 8'd10, 10'd22, 1'b1, "const10_full");

    // Ramp 1..9: S=45, Xavg=5, Xappr=5, Y=11
    for (int i = 1; i < 9; i++) step(1'b0, 8'(i), 10'd0, 1'b0, "fill");
    step(1'b0, 8'd9, 10'd11, 1'b1, "ramp_1_9");

    // All 255: maximum output 573
    for (int i = 0; i < 8; i++) step(1'b0, 8'd255, 10'd0, 1'b0, "fill");
    step(1'b0, 8'd255, 10'd573, 1'b1, "all_255_max");

    // Mixed window 200,100,50,25,12,6,3,1,0: S=397, Xavg=44, Xappr=25, Y=77
    step(1'b0, 8'd200, 10'd0, 1'b0, "fill");
    step(1'b0, 8'd100, 10'd0, 1'b0, "fill");
    step(1'b0, 8'd50,  10'd0, 1'b0, "fill");
    step(1'b0, 8'd25,  10'd0, 1'b0, "fill");
    step(1'b0, 8'd12,  10'd0, 1'b0, "fill");
    step(1'b0, 8'd6,   10'd0, 1'b0, "fill");
    step(1'b0, 8'd3,   10'd0, 1'b0, "fill");
    step(1'b0, 8'd1,   10'd0, 1'b0, "fill");
    step(1'b0, 8'd0,   10'd77, 1'b1, "mixed_desc");

    // Single 255 among zeros, walked through every window position: Y=31
    step(1'b1, 8'd0, 10'd0, 1'b1, "reset_before_spike");
    step(1'b0, 8'd255, 10'd31, 1'b1, "spike_pos0");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos1");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos2");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos3");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos4");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos5");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos6");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos7");
    step(1'b0, 8'd0, 10'd31, 1'b1, "spike_pos8");
    step(1'b0, 8'd0, 10'd0, 1'b1, "spike_gone");

    // Single 18 after reset: S=18, Xappr=0, Y=2; then mid-stream reset
    step(1'b1, 8'd0, 10'd0, 1'b1, "reset_before_18");
    step(1'b0, 8'd18, 10'd2, 1'b1, "single_18");
    step(1'b1, 8'd77, 10'd0, 1'b1, "midstream_reset");
    step(1'b0, 8'd10, 10'd1, 1'b1, "refill_first");
    for (int i = 1; i < 8; i++) step(1'b0, 8'd10, 10'd0, 1'b0, "fill");
    step(1'b0, 8'd10, 10'd22, 1'b1, "refill_full");

    // Flush the pending expectation of the registered build
    step(1'b0, 8'd0, 10'd0, 1'b0, "flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
